// File: rtl/vx_issue_steer_pkg.sv
// -----------------------------------------------------------------------------
// vx_issue_steer_pkg
// Shared issue-stage definitions: core-wide widths, the warp-to-slice mapping
// encodings and the steering function also used by the writeback and scheduler
// paths.
//   NW_WIDTH        warp-ID width for the core configuration (16 warps)
//   PERF_CTR_BITS   width of the performance counters
//   steer_map_e     STEER_MAP_INTERLEAVE (wid % slices) / STEER_MAP_BLOCK
//   steer_wid_to_slice(wid, mode, issue_width, num_warps) -> slice index
// -----------------------------------------------------------------------------
package vx_issue_steer_pkg;

  localparam int NW_WIDTH      = 4;
  localparam int PERF_CTR_BITS = 44;

  typedef enum logic [0:0] {
    STEER_MAP_INTERLEAVE = 1'b0,
    STEER_MAP_BLOCK      = 1'b1
  } steer_map_e;

  // Blocked mapping assumes num_warps is a multiple of issue_width, so each
  // slice owns a contiguous run of num_warps/issue_width warps.
  function automatic int unsigned steer_wid_to_slice(
    input int unsigned wid,
    input steer_map_e  mode,
    input int unsigned issue_width,
    input int unsigned num_warps
  );
    int unsigned slice_v;
    if (issue_width <= 32'd1) begin
      slice_v = 32'd0;
    end else begin
      case (mode)
        STEER_MAP_BLOCK: slice_v = wid / (num_warps / issue_width);
        default:         slice_v = wid % issue_width;
      endcase
    end
    return slice_v;
  endfunction

endpackage

// File: rtl/vx_issue_steer_chk.sv
// -----------------------------------------------------------------------------
// vx_issue_steer_chk
// Protocol checks for the issue steering block.
// Ports:
//   clk, reset   core clock, synchronous active-high reset
//   in_valid     decode valid
//   wid_ok       decode warp ID is inside 0..NUM_WARPS-1
//   credit_ovf   per-warp credit return while the warp already holds all credits
// -----------------------------------------------------------------------------
module vx_issue_steer_chk #(
  parameter int NUM_WARPS = 16
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 in_valid,
  input logic                 wid_ok,
  input logic [NUM_WARPS-1:0] credit_ovf
);

  // Decode must never present an out-of-range warp ID
  a_wid_range: assert property (@(posedge clk) disable iff (reset)
    in_valid |-> wid_ok);

  // Instruction buffers must not return more credits than they were given
  a_credit_ovf: assert property (@(posedge clk) disable iff (reset)
    credit_ovf == '0);

endmodule

// File: rtl/vx_issue_steer_fifo.sv
// -----------------------------------------------------------------------------
// vx_issue_steer_fifo
// Per-slice elastic buffer: DEPTH entries of WIDTH bits, count-based full/empty,
// head presented straight from the storage registers (no input bypass).
// Ports:
//   clk, reset      core clock, synchronous active-high reset
//   push, push_data write an entry (ignored when full)
//   pop             remove the head (ignored when empty)
//   out_valid       FIFO holds at least one entry
//   out_data        head entry
//   full            FIFO holds DEPTH entries
// -----------------------------------------------------------------------------
module vx_issue_steer_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_en_s;
  logic             pop_en_s;

  // Qualify push/pop against occupancy and expose status flags
  always_comb begin
    full      = (count_r == CNT_W'(DEPTH));
    out_valid = (count_r != '0);
    push_en_s = push && !full;
    pop_en_s  = pop && out_valid;
    out_data  = mem_r[rd_ptr_r];
  end

  // Entry storage; payload needs no reset since it is qualified by count
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vx_issue_steer.sv
// -----------------------------------------------------------------------------
// vx_issue_steer
// Issue-stage front end: steers the decode stream to ISSUE_WIDTH slice FIFOs by
// warp ID and throttles decode per warp with instruction-buffer credits.
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   in_valid/in_wid/in_data    decode instruction
//   in_ready                   decode instruction accepted this cycle
//   out_valid/out_wid/out_data per-slice head (slice i at bit/field i)
//   out_ready                  per-slice pop
//   ibuf_pop                   per-warp credit return
//   warp_stalled               per-warp "no credit left" (registered)
// Optional (macro VX_ISSUE_STEER_PERF_EN):
//   perf_stall_fifo            cycles refused because the target FIFO is full
//   perf_stall_credit          cycles refused only because the warp has no credit
//   perf_issued                accepted instructions
// -----------------------------------------------------------------------------
module vx_issue_steer
  import vx_issue_steer_pkg::*;
#(
  parameter int ISSUE_WIDTH = 4,
  parameter int NUM_WARPS   = 16,
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH       = 2,
  parameter int IBUF_SIZE   = 4,
  parameter int WID_MAP     = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [NW_WIDTH-1:0]               in_wid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic [ISSUE_WIDTH-1:0]            out_valid,
  output logic [ISSUE_WIDTH*NW_WIDTH-1:0]   out_wid,
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0] out_data,
  input  logic [ISSUE_WIDTH-1:0]            out_ready,
  input  logic [NUM_WARPS-1:0]              ibuf_pop,
  output logic [NUM_WARPS-1:0]              warp_stalled
`ifdef VX_ISSUE_STEER_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]          perf_stall_fifo,
  output logic [PERF_CTR_BITS-1:0]          perf_stall_credit,
  output logic [PERF_CTR_BITS-1:0]          perf_issued
`endif
);

  localparam int         SLICE_W  = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
  localparam int         CRD_W    = $clog2(IBUF_SIZE + 1);
  localparam int         ENTRY_W  = NW_WIDTH + DATA_WIDTH;
  localparam steer_map_e MAP_MODE = (WID_MAP == 1) ? STEER_MAP_BLOCK : STEER_MAP_INTERLEAVE;

  logic [SLICE_W-1:0]     slice_s;
  logic                   wid_ok_s;
  logic                   sel_full_s;
  logic                   sel_nocredit_s;
  logic                   accept_s;
  logic [ISSUE_WIDTH-1:0] fifo_full_s;
  logic [ISSUE_WIDTH-1:0] push_s;
  logic [ISSUE_WIDTH-1:0] pop_s;
  logic [NUM_WARPS-1:0]   accept_warp_s;
  logic [NUM_WARPS-1:0]   credit_zero_s;
  logic [NUM_WARPS-1:0]   credit_ovf_s;
  logic [CRD_W-1:0]       credit_r     [NUM_WARPS];
  logic [CRD_W-1:0]       credit_nxt_s [NUM_WARPS];

  // Target slice and warp-ID range check for the incoming instruction
  always_comb begin
    slice_s  = SLICE_W'(steer_wid_to_slice(32'(in_wid), MAP_MODE, ISSUE_WIDTH, NUM_WARPS));
    wid_ok_s = ({1'b0, in_wid} < (NW_WIDTH + 1)'(NUM_WARPS));
  end

  // Per-warp zero-credit flags from the current counters
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      credit_zero_s[w] = (credit_r[w] == '0);
    end
  end

  // Look up full/no-credit for the selected slice and warp; in_ready is built
  // from registered state only, so a same-cycle pop never frees room for input
  always_comb begin
    sel_full_s     = 1'b0;
    sel_nocredit_s = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      sel_full_s = sel_full_s | (fifo_full_s[i] & (slice_s == SLICE_W'(i)));
    end
    for (int w = 0; w < NUM_WARPS; w++) begin
      sel_nocredit_s = sel_nocredit_s | (credit_zero_s[w] & (in_wid == NW_WIDTH'(w)));
    end
    in_ready = wid_ok_s && !sel_full_s && !sel_nocredit_s;
    accept_s = in_valid && in_ready;
  end

  // Per-slice push decode and output handshakes
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      push_s[i] = accept_s && (slice_s == SLICE_W'(i));
    end
    pop_s = out_valid & out_ready;
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_slice
    logic [ENTRY_W-1:0] head_s;

    vx_issue_steer_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s[i]),
      .push_data ({in_wid, in_data}),
      .pop       (pop_s[i]),
      .out_valid (out_valid[i]),
      .out_data  (head_s),
      .full      (fifo_full_s[i])
    );

    assign out_wid[i*NW_WIDTH +: NW_WIDTH]       = head_s[ENTRY_W-1 -: NW_WIDTH];
    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = head_s[DATA_WIDTH-1:0];
  end

  // Credit next state: +1 on return, -1 on accept, unchanged on both; an
  // over-return at full credit saturates and is flagged to the checker
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      accept_warp_s[w] = accept_s && (in_wid == NW_WIDTH'(w));
      credit_ovf_s[w]  = ibuf_pop[w] && !accept_warp_s[w] && (credit_r[w] == CRD_W'(IBUF_SIZE));
      if (ibuf_pop[w] && !accept_warp_s[w] && !credit_ovf_s[w]) begin
        credit_nxt_s[w] = credit_r[w] + CRD_W'(1);
      end else if (accept_warp_s[w] && !ibuf_pop[w]) begin
        credit_nxt_s[w] = credit_r[w] - CRD_W'(1);
      end else begin
        credit_nxt_s[w] = credit_r[w];
      end
    end
  end

  // Credit counters and the registered stall flags derived from them
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        credit_r[w] <= CRD_W'(IBUF_SIZE);
      end
      warp_stalled <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        credit_r[w]     <= credit_nxt_s[w];
        warp_stalled[w] <= (credit_nxt_s[w] == '0);
      end
    end
  end

`ifdef VX_ISSUE_STEER_PERF_EN
  // Stall/issue counters; a full FIFO takes precedence over zero credit
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_fifo   <= '0;
      perf_stall_credit <= '0;
      perf_issued       <= '0;
    end else begin
      if (in_valid && wid_ok_s && sel_full_s) begin
        perf_stall_fifo <= perf_stall_fifo + PERF_CTR_BITS'(1);
      end
      if (in_valid && wid_ok_s && !sel_full_s && sel_nocredit_s) begin
        perf_stall_credit <= perf_stall_credit + PERF_CTR_BITS'(1);
      end
      if (accept_s) begin
        perf_issued <= perf_issued + PERF_CTR_BITS'(1);
      end
    end
  end
`endif

  vx_issue_steer_chk #(
    .NUM_WARPS (NUM_WARPS)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .wid_ok     (wid_ok_s),
    .credit_ovf (credit_ovf_s)
  );

endmodule

// File: tb/tb_vx_issue_steer.sv
// -----------------------------------------------------------------------------
// tb_vx_issue_steer
// Directed bench: dut0 uses interleaved mapping, dut1 blocked mapping; both
// 4 slices, 16 warps, 32-bit payload, DEPTH=2, IBUF_SIZE=4. Inputs change on the
// falling edge, outputs are compared on the falling edge (or #1 after it for
// combinational in_ready).
// -----------------------------------------------------------------------------
module tb_vx_issue_steer;
  import vx_issue_steer_pkg::*;

  localparam int IW = 4;
  localparam int NW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;

  logic                in_valid0, in_valid1;
  logic [NW_WIDTH-1:0] in_wid0, in_wid1;
  logic [DW-1:0]       in_data0, in_data1;
  logic                in_ready0, in_ready1;
  logic [IW-1:0]       out_valid0, out_valid1;
  logic [IW*NW_WIDTH-1:0] out_wid0, out_wid1;
  logic [IW*DW-1:0]    out_data0, out_data1;
  logic [IW-1:0]       out_ready0, out_ready1;
  logic [NW-1:0]       ibuf_pop0, ibuf_pop1;
  logic [NW-1:0]       warp_stalled0, warp_stalled1;
`ifdef VX_ISSUE_STEER_PERF_EN
  logic [PERF_CTR_BITS-1:0] pf_fifo0, pf_credit0, pf_issued0;
  logic [PERF_CTR_BITS-1:0] pf_fifo1, pf_credit1, pf_issued1;
`endif

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  vx_issue_steer #(
    .ISSUE_WIDTH(IW), .NUM_WARPS(NW), .DATA_WIDTH(DW), .DEPTH(2), .IBUF_SIZE(4), .WID_MAP(0)
  ) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid0), .in_wid(in_wid0), .in_data(in_data0), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_wid(out_wid0), .out_data(out_data0), .out_ready(out_ready0),
    .ibuf_pop(ibuf_pop0), .warp_stalled(warp_stalled0)
`ifdef VX_ISSUE_STEER_PERF_EN
    , .perf_stall_fifo(pf_fifo0), .perf_stall_credit(pf_credit0), .perf_issued(pf_issued0)
`endif
  );

  vx_issue_steer #(
    .ISSUE_WIDTH(IW), .NUM_WARPS(NW), .DATA_WIDTH(DW), .DEPTH(2), .IBUF_SIZE(4), .WID_MAP(1)
  ) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_wid(in_wid1), .in_data(in_data1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_wid(out_wid1), .out_data(out_data1), .out_ready(out_ready1),
    .ibuf_pop(ibuf_pop1), .warp_stalled(warp_stalled1)
`ifdef VX_ISSUE_STEER_PERF_EN
    , .perf_stall_fifo(pf_fifo1), .perf_stall_credit(pf_credit1), .perf_issued(pf_issued1)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [NW_WIDTH-1:0] w, input logic [DW-1:0] d);
    in_valid0 = v;
    in_wid0   = w;
    in_data0  = d;
  endtask

  // Safety net: the directed sequence is far shorter than this
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [NW_WIDTH-1:0] pp_wid  [4];
  logic [DW-1:0]       pp_data [4];

  initial begin
    pp_wid[0] = 4'd10; pp_wid[1] = 4'd14; pp_wid[2] = 4'd2; pp_wid[3] = 4'd6;
    pp_data[0] = 32'hD000_0000; pp_data[1] = 32'hD111_1111;
    pp_data[2] = 32'hD222_2222; pp_data[3] = 32'hD333_3333;

    reset = 1'b1;
    drive0(1'b0, 4'd0, 32'd0);
    in_valid1 = 1'b0; in_wid1 = 4'd0; in_data1 = 32'd0;
    out_ready0 = 4'b0000; out_ready1 = 4'b1111;
    ibuf_pop0 = 16'h0000; ibuf_pop1 = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_out_valid0", 64'(out_valid0), 64'h0);
    check_eq("rst_stalled0", 64'(warp_stalled0), 64'h0);
    check_eq("rst_out_valid1", 64'(out_valid1), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // wid 5, interleaved -> slice 1, one cycle latency
    drive0(1'b1, 4'd5, 32'hA5A5_0005);
    #1;
    check_eq("w5_ready", 64'(in_ready0), 64'h1);
    check_eq("w5_no_bypass", 64'(out_valid0), 64'h0);
    @(negedge clk);
    drive0(1'b0, 4'd0, 32'd0);
    check_eq("w5_out_valid", 64'(out_valid0), 64'h2);
    check_eq("w5_out_wid", 64'(out_wid0[1*NW_WIDTH +: NW_WIDTH]), 64'h5);
    check_eq("w5_out_data", 64'(out_data0[1*DW +: DW]), 64'hA5A5_0005);
    check_eq("w5_not_stalled", 64'(warp_stalled0), 64'h0);
    out_ready0 = 4'b0010;
    @(negedge clk);
    check_eq("w5_popped", 64'(out_valid0), 64'h0);
    out_ready0 = 4'b0000;
    ibuf_pop0 = 16'h0020;
    @(negedge clk);
    ibuf_pop0 = 16'h0000;

    // Fill slice 2; a slice-0 warp still gets through
    drive0(1'b1, 4'd2, 32'hB000_0002);
    #1 check_eq("s2_push1_ready", 64'(in_ready0), 64'h1);
    @(negedge clk);
    drive0(1'b1, 4'd6, 32'hC000_0006);
    #1 check_eq("s2_push2_ready", 64'(in_ready0), 64'h1);
    @(negedge clk);
    drive0(1'b1, 4'd10, 32'hEEEE_EEEE);
    #1 check_eq("s2_full_refuse", 64'(in_ready0), 64'h0);
    check_eq("s2_full_valid", 64'(out_valid0), 64'h4);
    drive0(1'b1, 4'd4, 32'hE000_0004);
    #1 check_eq("s0_accept_while_s2_full", 64'(in_ready0), 64'h1);
    @(negedge clk);
    check_eq("s0_s2_valid", 64'(out_valid0), 64'h5);

    // Full slice popped this cycle still refuses input
    drive0(1'b1, 4'd10, 32'hEEEE_EEEE);
    out_ready0 = 4'b0100;
    #1 check_eq("full_pop_refuse", 64'(in_ready0), 64'h0);
    check_eq("s2_head_wid_b", 64'(out_wid0[2*NW_WIDTH +: NW_WIDTH]), 64'h2);
    check_eq("s2_head_data_b", 64'(out_data0[2*DW +: DW]), 64'hB000_0002);
    drive0(1'b0, 4'd0, 32'd0);
    @(negedge clk);
    check_eq("s2_head_wid_c", 64'(out_wid0[2*NW_WIDTH +: NW_WIDTH]), 64'h6);
    check_eq("s2_head_data_c", 64'(out_data0[2*DW +: DW]), 64'hC000_0006);

    // Push and pop together for 2*DEPTH cycles: order kept across pointer wrap
    for (int k = 0; k < 4; k++) begin
      drive0(1'b1, pp_wid[k], pp_data[k]);
      out_ready0 = 4'b0100;
      #1 check_eq("pp_ready", 64'(in_ready0), 64'h1);
      @(negedge clk);
      check_eq("pp_valid", 64'(out_valid0[2]), 64'h1);
      check_eq("pp_wid", 64'(out_wid0[2*NW_WIDTH +: NW_WIDTH]), 64'(pp_wid[k]));
      check_eq("pp_data", 64'(out_data0[2*DW +: DW]), 64'(pp_data[k]));
    end
    // Occupancy stayed at one: exactly one more fits
    out_ready0 = 4'b0000;
    drive0(1'b1, 4'd2, 32'hF000_0002);
    #1 check_eq("pp_one_more_ready", 64'(in_ready0), 64'h1);
    @(negedge clk);
    drive0(1'b1, 4'd10, 32'hEEEE_EEEE);
    #1 check_eq("pp_then_full", 64'(in_ready0), 64'h0);
    drive0(1'b0, 4'd0, 32'd0);
    out_ready0 = 4'b1111;
    repeat (2) @(negedge clk);
    check_eq("drained", 64'(out_valid0), 64'h0);

    // Credits for warp 0 (slice 0 drains continuously)
    out_ready0 = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      drive0(1'b1, 4'd0, 32'h0000_0100 + 32'(k));
      #1 check_eq("w0_accept", 64'(in_ready0), 64'h1);
      @(negedge clk);
    end
    check_eq("w0_credit1_not_stalled", 64'(warp_stalled0[0]), 64'h0);
    drive0(1'b1, 4'd0, 32'h0000_0103);
    ibuf_pop0 = 16'h0001;
    #1 check_eq("w0_accept_with_pop", 64'(in_ready0), 64'h1);
    @(negedge clk);
    ibuf_pop0 = 16'h0000;
    check_eq("w0_accept_pop_unchanged", 64'(warp_stalled0[0]), 64'h0);
    drive0(1'b1, 4'd0, 32'h0000_0104);
    #1 check_eq("w0_last_credit", 64'(in_ready0), 64'h1);
    @(negedge clk);
    check_eq("w0_stalled", 64'(warp_stalled0), 64'h1);
    #1 check_eq("w0_zero_credit_refuse", 64'(in_ready0), 64'h0);
    drive0(1'b0, 4'd0, 32'd0);
    ibuf_pop0 = 16'h0001;
    @(negedge clk);
    ibuf_pop0 = 16'h0000;
    check_eq("w0_pop_unstall", 64'(warp_stalled0[0]), 64'h0);
    #1 check_eq("w0_ready_again", 64'(in_ready0), 64'h1);

    // Blocked mapping on dut1: 5 -> 1, 12 -> 3, 3 -> 0
    in_valid1 = 1'b1; in_wid1 = 4'd5; in_data1 = 32'h1111_0005;
    #1 check_eq("blk_w5_ready", 64'(in_ready1), 64'h1);
    @(negedge clk);
    check_eq("blk_w5_slice1", 64'(out_valid1), 64'h2);
    check_eq("blk_w5_wid", 64'(out_wid1[1*NW_WIDTH +: NW_WIDTH]), 64'h5);
    check_eq("blk_w5_data", 64'(out_data1[1*DW +: DW]), 64'h1111_0005);
    in_wid1 = 4'd12; in_data1 = 32'h1111_000C;
    @(negedge clk);
    check_eq("blk_w12_slice3", 64'(out_valid1), 64'h8);
    check_eq("blk_w12_wid", 64'(out_wid1[3*NW_WIDTH +: NW_WIDTH]), 64'hC);
    in_wid1 = 4'd3; in_data1 = 32'h1111_0003;
    @(negedge clk);
    check_eq("blk_w3_slice0", 64'(out_valid1), 64'h1);
    check_eq("blk_w3_wid", 64'(out_wid1[0 +: NW_WIDTH]), 64'h3);
    in_valid1 = 1'b0;
    @(negedge clk);
    check_eq("blk_drained", 64'(out_valid1), 64'h0);

    // Reset mid-stream discards entries and restores credits
    out_ready0 = 4'b0000;
    drive0(1'b1, 4'd0, 32'h0000_0200);
    @(negedge clk);
    check_eq("pre_rst_valid", 64'(out_valid0), 64'h1);
    check_eq("pre_rst_stalled", 64'(warp_stalled0), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 64'(out_valid0), 64'h0);
    check_eq("mid_rst_stalled", 64'(warp_stalled0), 64'h0);
    reset = 1'b0;
    drive0(1'b0, 4'd0, 32'd0);
    #1 check_eq("post_rst_w0_ready", 64'(in_ready0), 64'h1);

`ifdef VX_ISSUE_STEER_PERF_EN
    // 2 accepts, 3 cycles blocked by full slice 1, 4 accepts, 2 blocked by credit
    @(negedge clk);
    drive0(1'b1, 4'd1, 32'h0000_0301);
    @(negedge clk);
    drive0(1'b1, 4'd5, 32'h0000_0305);
    @(negedge clk);
    drive0(1'b1, 4'd9, 32'h0000_0309);
    repeat (3) @(negedge clk);
    out_ready0 = 4'b1000;
    drive0(1'b1, 4'd3, 32'h0000_0303);
    repeat (6) @(negedge clk);
    drive0(1'b0, 4'd0, 32'd0);
    check_eq("perf_stall_fifo", 64'(pf_fifo0), 64'd3);
    check_eq("perf_stall_credit", 64'(pf_credit0), 64'd2);
    check_eq("perf_issued", 64'(pf_issued0), 64'd6);
    check_eq("perf_w3_stalled", 64'(warp_stalled0[3]), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("perf_rst_fifo", 64'(pf_fifo0), 64'd0);
    check_eq("perf_rst_credit", 64'(pf_credit0), 64'd0);
    check_eq("perf_rst_issued", 64'(pf_issued0), 64'd0);
    check_eq("perf_rst_valid", 64'(out_valid0), 64'h0);
    check_eq("perf_rst_dut1", 64'(pf_issued1) | 64'(pf_fifo1) | 64'(pf_credit1), 64'd0);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
